// File: rtl/checkout_monitor.sv
// Basket tracker behind the item classifier: counts accepted scans and latches a blinking theft alarm.
// All outputs come straight from flops; clear and reset are the only ways out of ALARM.
//
// state  | meaning
// IDLE   | empty basket, waiting for the first scan
// ACTIVE | 1..MAX_ITEMS-1 items accepted
// FULL   | basket at capacity, non-stolen scans ignored
// ALARM  | theft seen, counts frozen, blink running
module checkout_monitor #(
  parameter int CNT_W        = 4,
  parameter int MAX_ITEMS    = 15,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan,
  input  logic [2:0]       upc,
  input  logic             discounted,
  input  logic             stolen,
  input  logic             clear,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count,
  output logic [2:0]       last_upc,
  output logic             full,
  output logic             alarm,
  output logic             alarm_blink
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_ITEMS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2,
    S_ALARM  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] item_cnt_q, item_cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [2:0]       last_upc_q, last_upc_d;
  logic             full_q, full_d;
  logic             alarm_q, alarm_d;
  logic             blink_q, blink_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic [CNT_W-1:0] item_cnt_inc;

  assign item_cnt_inc = item_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    item_cnt_d  = item_cnt_q;
    disc_cnt_d  = disc_cnt_q;
    last_upc_d  = last_upc_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    if (clear) begin
      state_d     = S_IDLE;
      item_cnt_d  = '0;
      disc_cnt_d  = '0;
      last_upc_d  = '0;
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ACTIVE: begin
          if (scan) begin
            if (stolen) begin
              state_d     = S_ALARM;
              blink_d     = 1'b1;
              blink_cnt_d = '0;
            end else begin
              item_cnt_d = item_cnt_inc;
              last_upc_d = upc;
              if (discounted) begin
                disc_cnt_d = disc_cnt_q + CNT_W'(1);
              end
              state_d = (item_cnt_inc == CNT_MAX) ? S_FULL : S_ACTIVE;
            end
          end
        end
        S_FULL: begin
          // Theft detection beats capacity; plain scans are dropped.
          if (scan && stolen) begin
            state_d     = S_ALARM;
            blink_d     = 1'b1;
            blink_cnt_d = '0;
          end
        end
        S_ALARM: begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    full_d  = (state_d == S_FULL);
    alarm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      item_cnt_q  <= '0;
      disc_cnt_q  <= '0;
      last_upc_q  <= '0;
      full_q      <= 1'b0;
      alarm_q     <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      item_cnt_q  <= item_cnt_d;
      disc_cnt_q  <= disc_cnt_d;
      last_upc_q  <= last_upc_d;
      full_q      <= full_d;
      alarm_q     <= alarm_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign item_count  = item_cnt_q;
  assign disc_count  = disc_cnt_q;
  assign last_upc    = last_upc_q;
  assign full        = full_q;
  assign alarm       = alarm_q;
  assign alarm_blink = blink_q;

endmodule

// File: tb/tb_checkout_monitor.sv
// Directed bench for checkout_monitor: a vector table for basket/capacity behaviour,
// then hand sequences for blink timing, clear-vs-scan and reset mid-alarm.
module tb_checkout_monitor;

  logic       clk = 1'b0;
  logic       reset_n, scan, discounted, stolen, clear;
  logic [2:0] upc;
  logic [3:0] item_count, disc_count;
  logic [2:0] last_upc;
  logic       full, alarm, alarm_blink;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rst_n, scn;
    logic [2:0] u;
    logic       dsc, stl, clr;
    logic [3:0] e_items, e_disc;
    logic [2:0] e_upc;
    logic       e_full, e_alarm, e_blink;
  } vec_t;

  vec_t vq[$];

  checkout_monitor #(.CNT_W(4), .MAX_ITEMS(3), .BLINK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .scan(scan), .upc(upc),
    .discounted(discounted), .stolen(stolen), .clear(clear),
    .item_count(item_count), .disc_count(disc_count), .last_upc(last_upc),
    .full(full), .alarm(alarm), .alarm_blink(alarm_blink)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic [2:0] u, logic d, logic st, logic c,
                              logic [3:0] ei, logic [3:0] ed, logic [2:0] eu,
                              logic ef, logic ea, logic eb);
    vec_t v;
    v.rst_n = r; v.scn = s; v.u = u; v.dsc = d; v.stl = st; v.clr = c;
    v.e_items = ei; v.e_disc = ed; v.e_upc = eu;
    v.e_full = ef; v.e_alarm = ea; v.e_blink = eb;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
  task automatic step(logic r, logic s, logic [2:0] u, logic d, logic st, logic c);
    reset_n = r; scan = s; upc = u; discounted = d; stolen = st; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic [3:0] ei, logic [3:0] ed, logic [2:0] eu,
                           logic ef, logic ea, logic eb);
    chk({tag, ".item_count"}, 8'(item_count), 8'(ei));
    chk({tag, ".disc_count"}, 8'(disc_count), 8'(ed));
    chk({tag, ".last_upc"},   8'(last_upc),   8'(eu));
    chk({tag, ".full"},       8'(full),       8'(ef));
    chk({tag, ".alarm"},      8'(alarm),      8'(ea));
    chk({tag, ".alarm_blink"},8'(alarm_blink),8'(eb));
  endtask

  initial begin
    reset_n = 1'b0; scan = 1'b0; upc = '0; discounted = 1'b0; stolen = 1'b0; clear = 1'b0;

    // rst scan upc dsc stl clr | items disc upc full alarm blink
    vq.push_back(mk(0,1,7,1,0,0, 0,0,0,0,0,0));  // reset holds despite scan
    vq.push_back(mk(0,1,7,1,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(1,1,5,1,0,0, 1,1,5,0,0,0));
    vq.push_back(mk(1,1,2,0,0,0, 2,1,2,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 2,1,2,0,0,0));
    vq.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));
    vq.push_back(mk(1,1,1,0,0,0, 1,0,1,0,0,0));
    vq.push_back(mk(1,1,3,1,0,0, 2,1,3,0,0,0));
    vq.push_back(mk(1,1,6,1,0,0, 3,2,6,1,0,0));  // reaches capacity
    vq.push_back(mk(1,1,4,1,0,0, 3,2,6,1,0,0));  // ignored in FULL
    vq.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));
    vq.push_back(mk(1,1,7,0,0,0, 1,0,7,0,0,0));
    vq.push_back(mk(1,1,1,0,0,0, 2,0,1,0,0,0));
    vq.push_back(mk(1,1,2,1,0,0, 3,1,2,1,0,0));
    vq.push_back(mk(1,1,5,0,1,0, 3,1,2,0,1,1));  // theft while FULL
    vq.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));

    foreach (vq[i]) begin
      step(vq[i].rst_n, vq[i].scn, vq[i].u, vq[i].dsc, vq[i].stl, vq[i].clr);
      check_all($sformatf("vec%0d", i), vq[i].e_items, vq[i].e_disc, vq[i].e_upc,
                vq[i].e_full, vq[i].e_alarm, vq[i].e_blink);
    end

    // Theft with one item, then blink pattern 1111 0000 1111 with scans ignored.
    step(1,1,4,1,0,0);
    check_all("t4.item", 1,1,4,0,0,0);
    step(1,1,6,0,1,0);
    check_all("t4.theft", 1,1,4,0,1,1);
    for (int k = 1; k < 12; k++) begin
      step(1, k[0], 3'(k), 1'b1, (k == 6), 1'b0);
      check_all($sformatf("t4.blink%0d", k), 1,1,4,0,1, ((k / 4) % 2) == 0);
    end

    // Clear and stolen scan together: clear wins.
    step(1,1,6,0,1,1);
    check_all("t5.clr_alarm", 0,0,0,0,0,0);
    step(1,1,3,0,0,0);
    check_all("t5.item", 1,0,3,0,0,0);
    step(1,1,6,1,1,1);
    check_all("t5.clr_scan", 0,0,0,0,0,0);

    // Reset mid-blink, then a fresh theft restarts blink at the start of its phase.
    step(1,1,2,0,0,0);
    check_all("t6.item", 1,0,2,0,0,0);
    step(1,1,5,0,1,0);
    check_all("t6.theft", 1,0,2,0,1,1);
    for (int k = 1; k < 6; k++) begin
      step(1,0,0,0,0,0);
      check_all($sformatf("t6.blink%0d", k), 1,0,2,0,1, ((k / 4) % 2) == 0);
    end
    step(0,1,1,0,1,0);
    check_all("t6.reset", 0,0,0,0,0,0);
    step(1,1,1,0,1,0);
    check_all("t6.retheft", 0,0,0,0,1,1);
    for (int k = 1; k < 6; k++) begin
      step(1,0,0,0,0,0);
      check_all($sformatf("t6.reblink%0d", k), 0,0,0,0,1, ((k / 4) % 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
